// File: rtl/inter_tx_scheduler_pkg.sv
// Shared types for the inter-board transmit scheduler: message layout,
// the turn-end message code and the send FSM states.
package inter_pkg;

   localparam int MSG_W = 22;

   typedef struct packed {
      logic       move_dir;
      logic [4:0] block_x;
      logic [2:0] block_y;
      logic [3:0] msg_type;
      logic [5:0] card;
      logic [2:0] sel_len;
   } msg_t;

   localparam logic [3:0] MSG_TURN_END = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } state_t;

   function automatic logic [3:0] msg_type_of(input logic [MSG_W-1:0] msg);
      msg_t m;
      m = msg_t'(msg);
      return m.msg_type;
   endfunction

endpackage

// File: rtl/inter_tx_scheduler_if.sv
// Message/handshake bundle between GameControl (master) and the scheduler
// (slave), including the sender-side ready and receive-side turn signals.
interface inter_tx_scheduler_if;
   import inter_pkg::*;

   logic             mv_valid;
   logic             mv_ready;
   logic [MSG_W-1:0] mv_msg;
   logic             cur_valid;
   logic [MSG_W-1:0] cur_msg;
   logic             inter_ready;
   logic             rx_en;
   logic [3:0]       rx_msg_type;
   logic             ctrl_en;
   logic [MSG_W-1:0] ctrl_msg;
   logic             transmit;
   logic             busy;
   logic             timeout_err;

   modport master (
      output mv_valid, mv_msg, cur_valid, cur_msg, inter_ready, rx_en, rx_msg_type,
      input  mv_ready, ctrl_en, ctrl_msg, transmit, busy, timeout_err
   );

   modport slave (
      input  mv_valid, mv_msg, cur_valid, cur_msg, inter_ready, rx_en, rx_msg_type,
      output mv_ready, ctrl_en, ctrl_msg, transmit, busy, timeout_err
   );

endinterface

// File: rtl/inter_tx_scheduler_fifo.sv
// Synchronous first-word-fall-through message FIFO; a push while full is
// taken only when the head is popped in the same cycle.
module inter_msg_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 22
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic [W-1:0] r_mem [DEPTH];
   logic         w_push_ok;
   logic         w_pop_ok;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/inter_tx_scheduler.sv
// Turn-token owner and send arbiter: queued moves beat the coalescing cursor
// slot. Optional per-phase handshake watchdog: INTER_SCHED_TIMEOUT_EN.
module inter_tx_scheduler #(
   parameter int         DEPTH        = 4,
   parameter logic       HOST         = 1'b1,
`ifdef INTER_SCHED_TIMEOUT_EN
   parameter logic [19:0] TIMEOUT     = 20'd1_000_000,
`endif
   parameter logic [3:0] MSG_TURN_END = 4'hF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 interboard_rst,
   inter_tx_scheduler_if.slave  bus
);
   import inter_pkg::MSG_W;
   import inter_pkg::state_t;
   import inter_pkg::ST_IDLE;
   import inter_pkg::ST_ISSUE;
   import inter_pkg::ST_WAIT_BUSY;
   import inter_pkg::ST_WAIT_DONE;
   import inter_pkg::msg_type_of;

   logic             w_rst;
   state_t           r_state;
   logic             r_ctrl_en;
   logic [MSG_W-1:0] r_ctrl_msg;
   logic             r_transmit;
   logic             r_busy;
   logic             r_cur_pending;
   logic [MSG_W-1:0] r_cur_msg;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [MSG_W-1:0] w_fifo_head;
   logic             w_can_issue;
   logic             w_pop_mv;
   logic             w_take_cur;
   logic             w_phase_expired;

   // A reset request from the other board is indistinguishable from a local one.
   assign w_rst       = rst | interboard_rst;
   assign w_can_issue = (r_state == ST_IDLE) && r_transmit && bus.inter_ready &&
                        (!w_fifo_empty || r_cur_pending);
   assign w_pop_mv    = w_can_issue && !w_fifo_empty;
   assign w_take_cur  = w_can_issue && w_fifo_empty;

   inter_msg_fifo #(.DEPTH(DEPTH), .W(MSG_W)) u_mv_fifo (
      .clk     (clk),
      .rst     (w_rst),
      .i_push  (bus.mv_valid),
      .i_data  (bus.mv_msg),
      .i_pop   (w_pop_mv),
      .o_data  (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // A fresh cursor write outranks clearing the slot for the one being issued.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_cur_pending <= 1'b0;
         r_cur_msg     <= '0;
      end else if (!r_transmit) begin
         r_cur_pending <= 1'b0;
      end else if (bus.cur_valid) begin
         r_cur_pending <= 1'b1;
         r_cur_msg     <= bus.cur_msg;
      end else if (w_take_cur) begin
         r_cur_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_state    <= ST_IDLE;
         r_ctrl_en  <= 1'b0;
         r_ctrl_msg <= '0;
         r_transmit <= HOST;
         r_busy     <= 1'b0;
      end else begin
         r_ctrl_en <= 1'b0;
         if (!r_transmit && bus.rx_en && (bus.rx_msg_type == MSG_TURN_END))
            r_transmit <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_can_issue) begin
                  r_state    <= ST_ISSUE;
                  r_ctrl_en  <= 1'b1;
                  r_ctrl_msg <= w_pop_mv ? w_fifo_head : r_cur_msg;
                  r_busy     <= 1'b1;
               end
            end
            ST_ISSUE: r_state <= ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
               if (!bus.inter_ready) begin
                  r_state <= ST_WAIT_DONE;
               end else if (w_phase_expired) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            ST_WAIT_DONE: begin
               if (bus.inter_ready) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  if (msg_type_of(r_ctrl_msg) == MSG_TURN_END) r_transmit <= 1'b0;
               end else if (w_phase_expired) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef INTER_SCHED_TIMEOUT_EN
   logic [19:0] r_phase_cnt;
   logic        r_timeout_err;
   logic        w_phase_wait;

   assign w_phase_wait    = ((r_state == ST_WAIT_BUSY) &&  bus.inter_ready) ||
                            ((r_state == ST_WAIT_DONE) && !bus.inter_ready);
   assign w_phase_expired = (r_phase_cnt == TIMEOUT - 20'd1);

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_phase_cnt   <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_phase_cnt <= (w_phase_wait && !w_phase_expired) ? r_phase_cnt + 20'd1 : 20'd0;
         if (w_phase_wait && w_phase_expired) r_timeout_err <= 1'b1;
      end
   end

   assign bus.timeout_err = r_timeout_err;
`else
   assign w_phase_expired = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   assign bus.mv_ready = !w_fifo_full;
   assign bus.ctrl_en  = r_ctrl_en;
   assign bus.ctrl_msg = r_ctrl_msg;
   assign bus.transmit = r_transmit;
   assign bus.busy     = r_busy;

endmodule

// File: tb/tb_inter_tx_scheduler.sv
// Scoreboard bench for inter_tx_scheduler: expected sends are queued as
// stimulus is driven and popped by a ctrl_en monitor.
module tb_inter_tx_scheduler;
   import inter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic interboard_rst;

   inter_tx_scheduler_if bus();

   inter_tx_scheduler #(.DEPTH(4), .HOST(1'b1)) dut (
      .clk            (clk),
      .rst            (rst),
      .interboard_rst (interboard_rst),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   int               checks = 0;
   int               errors = 0;
   logic [MSG_W-1:0] exp_q[$];
   logic [MSG_W-1:0] exp_msg;

   // Every ctrl_en pulse must match the oldest expected message.
   always @(negedge clk) begin
      if (bus.ctrl_en === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL send_order: ctrl_en with ctrl_msg=%h, required no send", bus.ctrl_msg);
         end else begin
            exp_msg = exp_q.pop_front();
            if (bus.ctrl_msg !== exp_msg) begin
               errors++;
               $display("FAIL send_order: ctrl_msg=%h, required %h", bus.ctrl_msg, exp_msg);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic wait_ctrl_en(input string name);
      int n = 0;
      while (bus.ctrl_en !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.ctrl_en !== 1'b1) begin
         errors++;
         $display("FAIL %s: ctrl_en=%b after %0d cycles, required 1", name, bus.ctrl_en, n);
      end
   endtask

   // Called at the ctrl_en cycle; emulates the sender going busy then idle.
   task automatic complete_send(input string name);
      bus.inter_ready = 1'b0;
      repeat (2) @(negedge clk);
      bus.inter_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s: busy=%b after handshake, required 0", name, bus.busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      interboard_rst = 1'b0;
      bus.mv_valid = 1'b0;
      bus.mv_msg = '0;
      bus.cur_valid = 1'b0;
      bus.cur_msg = '0;
      bus.inter_ready = 1'b1;
      bus.rx_en = 1'b0;
      bus.rx_msg_type = 4'h0;
      repeat (3) @(negedge clk);
      checks += 6;
      if (bus.ctrl_en !== 1'b0) begin errors++; $display("FAIL rst_ctrl_en: %b, required 0", bus.ctrl_en); end
      if (bus.ctrl_msg !== 22'h0) begin errors++; $display("FAIL rst_ctrl_msg: %h, required 0", bus.ctrl_msg); end
      if (bus.transmit !== 1'b1) begin errors++; $display("FAIL rst_transmit: %b, required 1", bus.transmit); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b, required 0", bus.busy); end
      if (bus.mv_ready !== 1'b1) begin errors++; $display("FAIL rst_mv_ready: %b, required 1", bus.mv_ready); end
      if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: %b, required 0", bus.timeout_err); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_move();
      bus.mv_valid = 1'b1;
      bus.mv_msg = 22'h0ABCDE;
      exp_q.push_back(22'h0ABCDE);
      @(negedge clk);
      bus.mv_valid = 1'b0;
      checks++;
      if (bus.ctrl_en !== 1'b0) begin errors++; $display("FAIL latency_early: ctrl_en=%b, required 0", bus.ctrl_en); end
      @(negedge clk);
      checks += 2;
      if (bus.ctrl_en !== 1'b1) begin errors++; $display("FAIL latency_2cyc: ctrl_en=%b, required 1", bus.ctrl_en); end
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_issue: busy=%b, required 1", bus.busy); end
      @(negedge clk);
      checks += 2;
      if (bus.ctrl_en !== 1'b0) begin errors++; $display("FAIL ctrl_en_pulse: ctrl_en=%b, required 0", bus.ctrl_en); end
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_wait: busy=%b, required 1", bus.busy); end
      @(negedge clk);
      bus.inter_ready = 1'b0;
      @(negedge clk);
      checks += 2;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_done: busy=%b, required 1", bus.busy); end
      if (bus.ctrl_msg !== 22'h0ABCDE) begin errors++; $display("FAIL ctrl_msg_hold: %h, required 0abcde", bus.ctrl_msg); end
      @(negedge clk);
      bus.inter_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_release: busy=%b, required 0", bus.busy); end
   endtask

   task automatic test_priority();
      bus.inter_ready = 1'b0;
      bus.mv_valid = 1'b1;
      bus.mv_msg = 22'h21B001;
      bus.cur_valid = 1'b1;
      bus.cur_msg = 22'h0C0002;
      exp_q.push_back(22'h21B001);
      exp_q.push_back(22'h0C0002);
      @(negedge clk);
      bus.mv_valid = 1'b0;
      bus.cur_valid = 1'b0;
      bus.inter_ready = 1'b1;
      wait_ctrl_en("prio_move");
      complete_send("prio_move_done");
      wait_ctrl_en("prio_cursor");
      exp_q.push_back(22'h0C0033);
      exp_q.push_back(22'h0C0044);
      bus.cur_valid = 1'b1;
      bus.cur_msg = 22'h0C0011;
      bus.inter_ready = 1'b0;
      @(negedge clk);
      bus.cur_msg = 22'h0C0022;
      @(negedge clk);
      bus.cur_msg = 22'h0C0033;
      bus.inter_ready = 1'b1;
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_cursor_writes: busy=%b, required 1", bus.busy); end
      @(negedge clk);
      bus.cur_msg = 22'h0C0044;
      @(negedge clk);
      bus.cur_valid = 1'b0;
      wait_ctrl_en("cursor_coalesced");
      complete_send("cursor_coalesced_done");
      wait_ctrl_en("cursor_write_on_issue");
      complete_send("cursor_write_on_issue_done");
   endtask

   task automatic test_fifo_full();
      bus.inter_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.mv_ready !== (i < 4)) begin
            errors++;
            $display("FAIL mv_ready_fill%0d: mv_ready=%b, required %b", i, bus.mv_ready, (i < 4));
         end
         bus.mv_valid = 1'b1;
         bus.mv_msg = 22'h150A00 + 22'(i);
         if (i < 4) exp_q.push_back(22'h150A00 + 22'(i));
         @(negedge clk);
      end
      bus.mv_valid = 1'b0;
      bus.inter_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ctrl_en("fifo_drain");
         complete_send("fifo_drain_done");
      end
      repeat (4) @(negedge clk);
      checks += 2;
      if (bus.mv_ready !== 1'b1) begin errors++; $display("FAIL mv_ready_drained: %b, required 1", bus.mv_ready); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL fifo_sends: %0d unsent, required 0", exp_q.size()); end
   endtask

   task automatic test_turn();
      bus.mv_valid = 1'b1;
      bus.mv_msg = 22'h2A1E05;
      exp_q.push_back(22'h2A1E05);
      @(negedge clk);
      bus.mv_valid = 1'b0;
      wait_ctrl_en("turn_end_send");
      complete_send("turn_end_done");
      checks++;
      if (bus.transmit !== 1'b0) begin errors++; $display("FAIL turn_release: transmit=%b, required 0", bus.transmit); end
      bus.mv_valid = 1'b1;
      bus.mv_msg = 22'h00C0A3;
      exp_q.push_back(22'h00C0A3);
      bus.cur_valid = 1'b1;
      bus.cur_msg = 22'h111111;
      @(negedge clk);
      bus.mv_valid = 1'b0;
      bus.cur_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL no_turn_no_issue: busy=%b, required 0", bus.busy); end
      bus.rx_en = 1'b1;
      bus.rx_msg_type = 4'h3;
      @(negedge clk);
      bus.rx_en = 1'b0;
      checks++;
      if (bus.transmit !== 1'b0) begin errors++; $display("FAIL rx_other_type: transmit=%b, required 0", bus.transmit); end
      bus.rx_en = 1'b1;
      bus.rx_msg_type = 4'hF;
      @(negedge clk);
      bus.rx_en = 1'b0;
      checks++;
      if (bus.transmit !== 1'b1) begin errors++; $display("FAIL rx_turn_end: transmit=%b, required 1", bus.transmit); end
      wait_ctrl_en("queued_during_turn");
      complete_send("queued_during_turn_done");
      repeat (5) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL cursor_dropped: busy=%b, required 0", bus.busy); end
   endtask

   task automatic test_interboard_rst();
      bus.mv_valid = 1'b1;
      bus.mv_msg = 22'h0C0C0C;
      exp_q.push_back(22'h0C0C0C);
      @(negedge clk);
      bus.mv_valid = 1'b0;
      wait_ctrl_en("rst_victim_send");
      bus.mv_valid = 1'b1;
      bus.mv_msg = 22'h3F0101;
      bus.inter_ready = 1'b0;
      @(negedge clk);
      bus.mv_valid = 1'b0;
      @(negedge clk);
      interboard_rst = 1'b1;
      bus.inter_ready = 1'b1;
      @(negedge clk);
      interboard_rst = 1'b0;
      checks += 4;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL ibrst_busy: %b, required 0", bus.busy); end
      if (bus.ctrl_en !== 1'b0) begin errors++; $display("FAIL ibrst_ctrl_en: %b, required 0", bus.ctrl_en); end
      if (bus.ctrl_msg !== 22'h0) begin errors++; $display("FAIL ibrst_ctrl_msg: %h, required 0", bus.ctrl_msg); end
      if (bus.transmit !== 1'b1) begin errors++; $display("FAIL ibrst_transmit: %b, required 1", bus.transmit); end
      repeat (6) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL ibrst_fifo_flushed: busy=%b, required 0", bus.busy); end
   endtask

   initial begin
      test_reset();
      test_single_move();
      test_priority();
      test_fifo_full();
      test_turn();
      test_interboard_rst();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drained: %0d expected sends missing, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
